// File: rtl/cursor_xy.sv
// Two-axis cursor position counter with edge-detected fire, runtime load,
// wrap/saturate ends and one-hot row/column select decode.
module cursor_xy #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int ROW_W    = $clog2(ROWS),
    parameter int COL_W    = $clog2(COLS),
    parameter int WRAP     = 1,
    parameter int INIT_ROW = 0,
    parameter int INIT_COL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fire,
    input  logic             row_en,
    input  logic             col_en,
    input  logic             add_n,
    input  logic             load,
    input  logic [ROW_W-1:0] load_row,
    input  logic [COL_W-1:0] load_col,
    output logic [ROW_W-1:0] row_idx,
    output logic [COL_W-1:0] col_idx,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_sel,
    output logic             moved,
    output logic             blocked
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_fire_q;
    logic             r_moved;
    logic             r_blocked;

    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic             w_row_mv;
    logic             w_row_bl;
    logic             w_col_mv;
    logic             w_col_bl;
    logic [ROW_W-1:0] w_load_row;
    logic [COL_W-1:0] w_load_col;
    logic             w_step;

    // Load clamping is only needed when the axis size leaves unused codes.
    generate
        if (ROWS == (1 << ROW_W)) begin : g_row_full
            assign w_load_row = load_row;
        end else begin : g_row_clamp
            assign w_load_row = (load_row > ROW_MAX) ? ROW_MAX : load_row;
        end
        if (COLS == (1 << COL_W)) begin : g_col_full
            assign w_load_col = load_col;
        end else begin : g_col_clamp
            assign w_load_col = (load_col > COL_MAX) ? COL_MAX : load_col;
        end
    endgenerate

    assign w_step = fire & ~r_fire_q & (row_en | col_en);

    // Row axis next position and move/limit flags for one step.
    always_comb begin
        w_row_nxt = r_row;
        w_row_mv  = 1'b0;
        w_row_bl  = 1'b0;
        if (!add_n) begin
            if (r_row == ROW_MAX) begin
                if (WRAP != 0) begin
                    w_row_nxt = {ROW_W{1'b0}};
                    w_row_mv  = 1'b1;
                end else begin
                    w_row_bl  = 1'b1;
                end
            end else begin
                w_row_nxt = r_row + ROW_W'(1);
                w_row_mv  = 1'b1;
            end
        end else begin
            if (r_row == {ROW_W{1'b0}}) begin
                if (WRAP != 0) begin
                    w_row_nxt = ROW_MAX;
                    w_row_mv  = 1'b1;
                end else begin
                    w_row_bl  = 1'b1;
                end
            end else begin
                w_row_nxt = r_row - ROW_W'(1);
                w_row_mv  = 1'b1;
            end
        end
    end

    // Column axis next position and move/limit flags for one step.
    always_comb begin
        w_col_nxt = r_col;
        w_col_mv  = 1'b0;
        w_col_bl  = 1'b0;
        if (!add_n) begin
            if (r_col == COL_MAX) begin
                if (WRAP != 0) begin
                    w_col_nxt = {COL_W{1'b0}};
                    w_col_mv  = 1'b1;
                end else begin
                    w_col_bl  = 1'b1;
                end
            end else begin
                w_col_nxt = r_col + COL_W'(1);
                w_col_mv  = 1'b1;
            end
        end else begin
            if (r_col == {COL_W{1'b0}}) begin
                if (WRAP != 0) begin
                    w_col_nxt = COL_MAX;
                    w_col_mv  = 1'b1;
                end else begin
                    w_col_bl  = 1'b1;
                end
            end else begin
                w_col_nxt = r_col - COL_W'(1);
                w_col_mv  = 1'b1;
            end
        end
    end

    // Position, fire history and status pulses; load wins over a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= ROW_W'(INIT_ROW);
            r_col     <= COL_W'(INIT_COL);
            r_fire_q  <= 1'b1;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_fire_q  <= fire;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            if (load) begin
                r_row <= w_load_row;
                r_col <= w_load_col;
            end else if (w_step) begin
                if (row_en) r_row <= w_row_nxt;
                if (col_en) r_col <= w_col_nxt;
                r_moved   <= (row_en & w_row_mv) | (col_en & w_col_mv);
                r_blocked <= (row_en & w_row_bl) | (col_en & w_col_bl);
            end
        end
    end

    assign row_idx = r_row;
    assign col_idx = r_col;
    assign moved   = r_moved;
    assign blocked = r_blocked;
    assign row_sel = {{(ROWS-1){1'b0}}, 1'b1} << r_row;
    assign col_sel = {{(COLS-1){1'b0}}, 1'b1} << r_col;

endmodule

// File: tb/tb_cursor_xy.sv
// Bench for cursor_xy: a wrapping 5x4 instance and a saturating 4x4 instance
// share stimulus and are compared against a position model every cycle.
module tb_cursor_xy;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fire = 1'b1;
    logic       row_en = 1'b0;
    logic       col_en = 1'b0;
    logic       add_n = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_row = 3'd0;
    logic [1:0] load_col = 2'd0;

    logic [2:0] a_row;
    logic [1:0] a_col;
    logic [4:0] a_rsel;
    logic [3:0] a_csel;
    logic       a_mv, a_bl;
    logic [1:0] b_row;
    logic [1:0] b_col;
    logic [3:0] b_rsel;
    logic [3:0] b_csel;
    logic       b_mv, b_bl;

    int checks = 0;
    int failures = 0;

    int m_row[2], m_col[2], m_fq[2], m_mv[2], m_bl[2];
    int NR[2] = '{5, 4};
    int NC[2] = '{4, 4};
    int WR[2] = '{1, 0};

    always #5 clk = ~clk;

    cursor_xy #(.ROWS(5), .COLS(4), .WRAP(1), .INIT_ROW(2), .INIT_COL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .fire(fire), .row_en(row_en), .col_en(col_en),
        .add_n(add_n), .load(load), .load_row(load_row), .load_col(load_col),
        .row_idx(a_row), .col_idx(a_col), .row_sel(a_rsel), .col_sel(a_csel),
        .moved(a_mv), .blocked(a_bl));

    cursor_xy #(.ROWS(4), .COLS(4), .WRAP(0), .INIT_ROW(2), .INIT_COL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .fire(fire), .row_en(row_en), .col_en(col_en),
        .add_n(add_n), .load(load), .load_row(load_row[1:0]), .load_col(load_col),
        .row_idx(b_row), .col_idx(b_col), .row_sel(b_rsel), .col_sel(b_csel),
        .moved(b_mv), .blocked(b_bl));

    typedef struct {
        logic       fire, re, ce, addn, ld;
        logic [2:0] lr;
        logic [1:0] lc;
        int         er, ec, em, eb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_row[d] = 2; m_col[d] = 1; m_fq[d] = 1; m_mv[d] = 0; m_bl[d] = 0;
        end
    endtask

    // Move one axis by +/-1: wrap modulo the axis size, or refuse past the ends.
    task automatic axis(inout int p, input int n, input int w, inout int mv, inout int bl);
        int dir = add_n ? -1 : 1;
        if (w != 0) begin
            p = (p + dir + n) % n;
            mv = 1;
        end else if (p + dir < 0 || p + dir > n - 1) begin
            bl = 1;
        end else begin
            p = p + dir;
            mv = 1;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int lr = (d == 0) ? int'(load_row) : int'(load_row[1:0]);
            int lc = int'(load_col);
            m_mv[d] = 0; m_bl[d] = 0;
            if (load) begin
                m_row[d] = (lr > NR[d] - 1) ? NR[d] - 1 : lr;
                m_col[d] = (lc > NC[d] - 1) ? NC[d] - 1 : lc;
            end else if (fire && m_fq[d] == 0 && (row_en || col_en)) begin
                if (row_en) axis(m_row[d], NR[d], WR[d], m_mv[d], m_bl[d]);
                if (col_en) axis(m_col[d], NC[d], WR[d], m_mv[d], m_bl[d]);
            end
            m_fq[d] = int'(fire);
        end
    endtask

    task automatic cmp_model();
        chk("A.row", 32'(a_row), 32'(m_row[0]));
        chk("A.col", 32'(a_col), 32'(m_col[0]));
        chk("A.row_sel", 32'(a_rsel), 32'(1) << m_row[0]);
        chk("A.col_sel", 32'(a_csel), 32'(1) << m_col[0]);
        chk("A.moved", 32'(a_mv), 32'(m_mv[0]));
        chk("A.blocked", 32'(a_bl), 32'(m_bl[0]));
        chk("B.row", 32'(b_row), 32'(m_row[1]));
        chk("B.col", 32'(b_col), 32'(m_col[1]));
        chk("B.row_sel", 32'(b_rsel), 32'(1) << m_row[1]);
        chk("B.col_sel", 32'(b_csel), 32'(1) << m_col[1]);
        chk("B.moved", 32'(b_mv), 32'(m_mv[1]));
        chk("B.blocked", 32'(b_bl), 32'(m_bl[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic f, input logic re, input logic ce, input logic an,
                         input logic ld, input logic [2:0] lr, input logic [1:0] lc);
        fire = f; row_en = re; col_en = ce; add_n = an; load = ld;
        load_row = lr; load_col = lc;
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 2,1,0,0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 2,1,0,0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 3,1,1,0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 3,1,0,0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 3,1,0,0};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 4,1,1,0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 4,1,0,0};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 0,1,1,0};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,3'd0,2'd0, 0,1,0,0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,3'd0,2'd0, 4,1,1,0};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,3'd0,2'd0, 4,1,0,0};
        vecs[11] = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'd0,2'd0, 3,0,1,0};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'd7,2'd2, 4,2,0,0};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd7,2'd2, 4,2,0,0};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 4,2,0,0};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0, 4,2,0,0};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,2'd0, 4,2,0,0};

        // Reset with fire held high, then release while fire stays high.
        model_reset();
        #12;
        chk("rst.A.row", 32'(a_row), 32'd2);
        chk("rst.A.col", 32'(a_col), 32'd1);
        chk("rst.A.row_sel", 32'(a_rsel), 32'b00100);
        chk("rst.A.col_sel", 32'(a_csel), 32'b0010);
        chk("rst.B.row_sel", 32'(b_rsel), 32'b0100);
        chk("rst.A.moved", 32'(a_mv), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].fire, vecs[i].re, vecs[i].ce, vecs[i].addn, vecs[i].ld,
                  vecs[i].lr, vecs[i].lc);
            tick();
            chk($sformatf("vec%0d.row", i), 32'(a_row), 32'(vecs[i].er));
            chk($sformatf("vec%0d.col", i), 32'(a_col), 32'(vecs[i].ec));
            chk($sformatf("vec%0d.moved", i), 32'(a_mv), 32'(vecs[i].em));
            chk($sformatf("vec%0d.blocked", i), 32'(a_bl), 32'(vecs[i].eb));
        end

        // Saturating diagonal: row 1 -> 2, column held at 3.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd3);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();
        chk("diag.B.row", 32'(b_row), 32'd2);
        chk("diag.B.col", 32'(b_col), 32'd3);
        chk("diag.B.moved", 32'(b_mv), 32'd1);
        chk("diag.B.blocked", 32'(b_bl), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();

        // Column at max with fire held six cycles: blocked once, no move.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("hold%0d.B.col", i), 32'(b_col), 32'd3);
            chk($sformatf("hold%0d.B.blocked", i), 32'(b_bl), (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("hold%0d.B.moved", i), 32'(b_mv), 32'd0);
        end

        // Reset pulse between a fire edge and the clock that would take it.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        tick();
        fire = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.A.row", 32'(a_row), 32'd2);
        chk("arst.A.col", 32'(a_col), 32'd1);
        chk("arst.B.row", 32'(b_row), 32'd2);
        #1 rst_n = 1'b1;
        tick();
        chk("arst.A.moved", 32'(a_mv), 32'd0);
        chk("arst.A.row_after", 32'(a_row), 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cursor_xy.md
Name: cursor_xy

Overview:
- Two-axis cursor position counter for the wire-select path. Generalises the single-axis one-hot selector to independent row and column axes of arbitrary (non-power-of-two) size.
- Fire is edge-detected. Wrap or saturate mode is a parameter. A runtime load loads the position, and a move/blocked status pulse is produced.
- Sits between the button/command decode and the display/VDC drive; its one-hot outputs drive the row and column select lines directly.

Parameters:
- ROWS, 4, number of row positions (>=2, any integer).
- COLS, 4, number of column positions (>=2, any integer).
- ROW_W, $clog2(ROWS), row index width.
- COL_W, $clog2(COLS), column index width.
- WRAP, 1, 1 = wrap at the ends, 0 = saturate at the ends.
- INIT_ROW, 0, row index after reset (must be < ROWS).
- INIT_COL, 0, column index after reset (must be < COLS).

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fire  input  1  step request, level input; only the 0->1 transition acts.
- row_en  input  1  a fire edge moves the row axis.
- col_en  input  1  a fire edge moves the column axis.
- add_n  input  1  0 = increment, 1 = decrement; applies to both enabled axes.
- load  input  1  synchronous load strobe, level-sensitive.
- load_row  input  ROW_W  row value for load.
- load_col  input  COL_W  column value for load.
- row_idx  output  ROW_W  current row, registered.
- col_idx  output  COL_W  current column, registered.
- row_sel  output  ROWS  one-hot of row_idx.
- col_sel  output  COLS  one-hot of col_idx.
- moved  output  1  one-cycle pulse: the previous edge changed the position by a step.
- blocked  output  1  one-cycle pulse: the previous edge was a step that was refused because of saturation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - row_idx=INIT_ROW, col_idx=INIT_COL.
  - fire_q=1, so a fire held high through reset does not step on release.
  - moved=0, blocked=0.
- Edge detect:
  - fire_q <= fire every cycle.
  - step = fire & ~fire_q & (row_en | col_en).
  - A step updates the index on the same rising edge that first samples fire=1. Latency 1 clock from input to registered index.
  - fire held high for N cycles gives exactly one step.
- Priority: load > step.
  - load=1 writes both indices and suppresses any step that cycle.
  - moved and blocked are 0 after a load cycle.
  - fire_q still updates during load, so a fire edge coincident with load is consumed, not deferred.
- Load range:
  - load_row >= ROWS clamps to ROWS-1.
  - load_col >= COLS clamps to COLS-1.
- Per-axis step, applied only when that axis's enable is 1:
  - Both enables set = diagonal move in the same direction on one edge.
  - Increment at max (ROWS-1 / COLS-1): WRAP=1 -> 0; WRAP=0 -> hold.
  - Decrement at 0: WRAP=1 -> max; WRAP=0 -> hold.
  - Wrap uses the axis size, not 2^W (e.g. ROWS=5: 4 -> 0, 0 -> 4).
- Status, registered and valid the cycle after the step edge:
  - moved=1 if any enabled axis changed.
  - blocked=1 if any enabled axis held at a limit (WRAP=0 only).
  - Diagonal with one axis blocked: both moved=1 and blocked=1.
  - Both pulses are 0 in all other cycles.
- Selects:
  - row_sel and col_sel are combinational decodes of the registered indices: exactly one bit set, bit[idx]=1. Never all-zero or X.
  - Indices never leave range, so no out-of-range decode is reachable.
- Reset mid-operation:
  - Asynchronous clear overrides any pending step or load.
  - The first fire edge after deassertion requires fire to go low and then high.

Test Plan:
- Reset with INIT_ROW=2, INIT_COL=1 and fire held 1, then release rst_n while fire stays 1 -> row_idx=2, col_idx=1, row_sel=4'b0100, col_sel=4'b0010, no step. Drop fire and raise it with row_en=1, add_n=0 -> row_idx=3, moved=1 for exactly one cycle.
- WRAP=1, ROWS=5, row at 4, row_en=1, add_n=0, one fire edge -> row_idx=0. Then add_n=1, one edge -> row_idx=4, row_sel=5'b10000.
- WRAP=0, COLS=4, col at 3, col_en=1, add_n=0, fire held high 6 cycles -> col_idx stays 3, blocked=1 for exactly one cycle, moved=0.
- Both enables set, add_n=0, row=1, col=3, WRAP=0 -> row=2, col=3, moved=1 and blocked=1 in the same cycle.
- load=1 with load_row=7 (ROWS=5), load_col=2, and a coincident fire edge -> row_idx=4, col_idx=2, no step applied. Fire still held afterwards causes no step.
- rst_n pulsed low between a fire edge and the next clock -> indices return to INIT values asynchronously, and moved stays 0.
